// File: rtl/gray_step_monitor.sv
// gray_step_monitor
//   Consumes the Gray code from the upstream counter. Each enabled cycle the
//   sample is converted to binary and compared with the last accepted value.
//   A change of +1 counts as a forward step and -1 as a backward step. Any
//   other change latches a sticky fault. Steps is a position counter that
//   wraps modulo 2^CNT_W.
//
// Ports:
//   Clk    - system clock, rising edge
//   Reset  - synchronous active-high reset, takes priority over En
//   En     - sample enable; GrayIn is ignored when low
//   GrayIn - Gray-coded value from the upstream counter
//   Binary - registered binary value of the last accepted sample
//   Steps  - step position: +1 forward, -1 backward, wraps
//   Dir    - direction of the last step (1 forward, 0 backward)
//   Wrap   - one-cycle pulse on a forward step from all-ones to zero
//   Locked - high once a reference sample has been taken
//   Error  - sticky illegal-transition flag
module gray_step_monitor #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [WIDTH-1:0] GrayIn,
  output logic [WIDTH-1:0] Binary,
  output logic [CNT_W-1:0] Steps,
  output logic             Dir,
  output logic             Wrap,
  output logic             Locked,
  output logic             Error
);

  typedef enum logic [1:0] {
    INIT  = 2'b00,
    TRACK = 2'b01,
    FAULT = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] d;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    b = '0;
    b[WIDTH-1] = GrayIn[WIDTH-1];
    for (int unsigned i = WIDTH - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ GrayIn[i-1];
    end
  end

  // Modular distance from the last accepted sample.
  assign d = b - Binary;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= INIT;
      Binary <= '0;
      Steps  <= '0;
      Dir    <= 1'b0;
      Wrap   <= 1'b0;
      Locked <= 1'b0;
      Error  <= 1'b0;
    end else begin
      // Wrap is a pulse: cleared every cycle unless a qualifying step sets it.
      Wrap <= 1'b0;
      case (state)
        INIT: begin
          if (En) begin
            Binary <= b;
            Locked <= 1'b1;
            state  <= TRACK;
          end
        end
        TRACK: begin
          if (En) begin
            if (d == WIDTH'(1)) begin
              Binary <= b;
              Steps  <= Steps + CNT_W'(1);
              Dir    <= 1'b1;
              Wrap   <= (Binary == '1);
            end else if (d == '1) begin
              Binary <= b;
              Steps  <= Steps - CNT_W'(1);
              Dir    <= 1'b0;
            end else if (d != '0) begin
              Binary <= b;
              Error  <= 1'b1;
              state  <= FAULT;
            end
          end
        end
        FAULT: begin
          if (En) begin
            Binary <= b;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_step_monitor.sv
module tb_gray_step_monitor;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic [2:0] GrayIn;
  logic [2:0] Binary;
  logic [7:0] Steps;
  logic       Dir;
  logic       Wrap;
  logic       Locked;
  logic       Error;

  int n_checks = 0;
  int n_fail   = 0;

  gray_step_monitor #(.WIDTH(3), .CNT_W(8)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .En     (En),
    .GrayIn (GrayIn),
    .Binary (Binary),
    .Steps  (Steps),
    .Dir    (Dir),
    .Wrap   (Wrap),
    .Locked (Locked),
    .Error  (Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Apply inputs, take one rising edge, then settle before sampling outputs.
  task automatic tick(input logic rst, input logic en, input logic [2:0] g);
    Reset  = rst;
    En     = en;
    GrayIn = g;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 3'b000);
    tick(1'b0, 1'b0, 3'b000);
  endtask

  logic [2:0] seq_g [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                            3'b111, 3'b101, 3'b100, 3'b000};
  logic [2:0] seq_b [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

  initial begin
    Reset = 1'b0; En = 1'b0; GrayIn = 3'b000;
    #2;

    // Reset values
    tick(1'b1, 1'b0, 3'b000);
    check("rst_binary", Binary, 0);
    check("rst_steps",  Steps,  0);
    check("rst_dir",    Dir,    0);
    check("rst_wrap",   Wrap,   0);
    check("rst_locked", Locked, 0);
    check("rst_error",  Error,  0);
    tick(1'b0, 1'b0, 3'b000);
    check("idle_locked", Locked, 0);

    // Full forward lap with wrap
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, 1'b1, seq_g[i]);
      check($sformatf("fwd_binary_%0d", i), Binary, seq_b[i]);
      check($sformatf("fwd_steps_%0d", i),  Steps,  i);
      check($sformatf("fwd_wrap_%0d", i),   Wrap,   (i == 8) ? 1 : 0);
      check($sformatf("fwd_error_%0d", i),  Error,  0);
      check($sformatf("fwd_locked_%0d", i), Locked, 1);
    end
    check("fwd_dir", Dir, 1);
    tick(1'b0, 1'b1, 3'b000);
    check("fwd_wrap_clear", Wrap, 0);

    // Backward step from 0 to 7, Steps underflows
    do_reset();
    tick(1'b0, 1'b1, 3'b000);
    tick(1'b0, 1'b1, 3'b100);
    check("bwd_binary", Binary, 7);
    check("bwd_steps",  Steps,  255);
    check("bwd_dir",    Dir,    0);
    check("bwd_wrap",   Wrap,   0);
    check("bwd_error",  Error,  0);
    // Forward from 255 overflows back to 0; 7->0 forward pulses Wrap
    tick(1'b0, 1'b1, 3'b000);
    check("ovf_steps",  Steps,  0);
    check("ovf_dir",    Dir,    1);
    check("ovf_wrap",   Wrap,   1);

    // Illegal jump 1 -> 5, then frozen in FAULT
    do_reset();
    tick(1'b0, 1'b1, 3'b000);
    tick(1'b0, 1'b1, 3'b001);
    tick(1'b0, 1'b1, 3'b111);
    check("ill_error",  Error,  1);
    check("ill_steps",  Steps,  1);
    check("ill_binary", Binary, 5);
    check("ill_dir",    Dir,    1);
    tick(1'b0, 1'b1, 3'b101);
    check("flt_binary1", Binary, 6);
    check("flt_steps1",  Steps,  1);
    check("flt_error1",  Error,  1);
    tick(1'b0, 1'b1, 3'b100);
    check("flt_binary2", Binary, 7);
    check("flt_steps2",  Steps,  1);
    check("flt_error2",  Error,  1);
    check("flt_wrap2",   Wrap,   0);

    // En=0 freeze from Binary=2, Steps=2
    do_reset();
    tick(1'b0, 1'b1, 3'b000);
    tick(1'b0, 1'b1, 3'b001);
    tick(1'b0, 1'b1, 3'b011);
    check("pre_en_binary", Binary, 2);
    check("pre_en_steps",  Steps,  2);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, (i % 3 == 0) ? 3'b000 : ((i % 3 == 1) ? 3'b011 : 3'b110));
      check($sformatf("en0_binary_%0d", i), Binary, 2);
      check($sformatf("en0_steps_%0d", i),  Steps,  2);
      check($sformatf("en0_wrap_%0d", i),   Wrap,   0);
      check($sformatf("en0_error_%0d", i),  Error,  0);
    end

    // Hold 010 (binary 3): first edge is a forward step, then no change
    tick(1'b0, 1'b1, 3'b010);
    check("hold_first_steps", Steps, 3);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 3'b010);
      check($sformatf("hold_steps_%0d", i),  Steps,  3);
      check($sformatf("hold_binary_%0d", i), Binary, 3);
      check($sformatf("hold_wrap_%0d", i),   Wrap,   0);
      check($sformatf("hold_error_%0d", i),  Error,  0);
    end

    // Reset with En=1 after Steps=5 and Error=1
    do_reset();
    tick(1'b0, 1'b1, 3'b000);
    tick(1'b0, 1'b1, 3'b001);
    tick(1'b0, 1'b1, 3'b011);
    tick(1'b0, 1'b1, 3'b010);
    tick(1'b0, 1'b1, 3'b110);
    tick(1'b0, 1'b1, 3'b111);
    check("pre_rst_steps", Steps, 5);
    tick(1'b0, 1'b1, 3'b000);
    check("pre_rst_error", Error, 1);
    tick(1'b1, 1'b1, 3'b011);
    check("rst_en_binary", Binary, 0);
    check("rst_en_steps",  Steps,  0);
    check("rst_en_dir",    Dir,    0);
    check("rst_en_wrap",   Wrap,   0);
    check("rst_en_locked", Locked, 0);
    check("rst_en_error",  Error,  0);
    tick(1'b0, 1'b1, 3'b011);
    check("ref_binary", Binary, 2);
    check("ref_steps",  Steps,  0);
    check("ref_locked", Locked, 1);
    check("ref_error",  Error,  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_step_monitor.md
Name: gray_step_monitor

Overview:
- Downstream consumer of the 3-bit Gray counter.
- Samples the Gray code each enabled cycle, converts it to binary, and classifies each change as a forward step, a backward step, or illegal.
- Keeps a signed-agnostic step position, pulses on forward wrap, and raises a sticky fault on any multi-step jump.
- Feeds the status/display logic that currently reads the counter directly.

Parameters:
WIDTH, 3, width of the Gray input and binary output
CNT_W, 8, width of the step position counter

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous active-high reset
En  input  1  sample enable; GrayIn is ignored when low
GrayIn  input  WIDTH  Gray-coded value from upstream counter
Binary  output  WIDTH  registered binary of last accepted sample
Steps  output  CNT_W  position: +1 per forward step, -1 per backward step, wraps mod 2^CNT_W
Dir  output  1  direction of last step: 1 forward, 0 backward
Wrap  output  1  one-cycle pulse on forward step from all-ones to 0
Locked  output  1  high once a reference sample has been taken
Error  output  1  sticky illegal-transition flag

Behaviour:
- One clock Clk. Reset is synchronous and active-high; it has priority over En.
- Reset values: Binary=0, Steps=0, Dir=0, Wrap=0, Locked=0, Error=0, state=INIT.
- Conversion is combinational: b[MSB]=g[MSB]; b[i]=b[i+1]^g[i].
- All outputs are registered and update on the edge that samples GrayIn. Latency is 1 cycle from input to output.
- Whenever En=0: no state, Binary, Steps, Dir, Locked or Error change, and Wrap=0.
- Wrap is 0 on every cycle except the single cycle after a qualifying forward step.
- State INIT, En=1:
  - Binary<=b, Locked<=1, go to TRACK.
  - No step counted, no error, Wrap=0.
- State TRACK, En=1: compute d=(b-Binary) mod 2^WIDTH.
  - d=0: hold everything; Wrap=0.
  - d=1 (forward): Binary<=b, Steps<=Steps+1, Dir<=1. Wrap<=1 iff Binary was all-ones; otherwise Wrap<=0.
  - d=all-ones (backward): Binary<=b, Steps<=Steps-1, Dir<=0, Wrap<=0.
  - Any other d: Error<=1, go to FAULT. Binary<=b. Steps and Dir hold. Wrap<=0.
- State FAULT:
  - Binary keeps following b on En=1.
  - Steps, Dir and Wrap are frozen; Wrap stays 0.
  - Error stays 1.
  - Only Reset leaves FAULT.
- Steps wraps both ways: 255+1=0 and 0-1=255 for CNT_W=8.
- Reset asserted mid-sequence: next edge returns to INIT with all reset values. The first sample after Reset deasserts is a new reference, not a step.
- Unused state encodings recover to INIT.

Test Plan:
- Reset, then En=1 with GrayIn=000,001,011,010,110,111,101,100,000, one per cycle:
  - Locked=1 after the first edge.
  - Steps=8, Dir=1, Binary=0 at the end.
  - Wrap=1 only in the cycle after 000 follows 100.
  - Error=0 throughout.
- Reference 000, then GrayIn=100:
  - Binary=7, Steps=255, Dir=0, Wrap=0, Error=0.
- Reference 000, then 001, then 111 (binary 1 to 5):
  - Error=1, Steps=1 frozen, Binary=5.
  - Following legal steps 101, 100: Steps stays 1, Error stays 1, Binary=6 then 7.
- En=0 while GrayIn toggles 000/011/110 for 5 cycles, starting with Binary=2, Steps=2:
  - Binary=2, Steps=2, Wrap=0 and Error=0 unchanged.
- Reset=1 and En=1 on the same edge, with GrayIn=011, after Steps=5 and Error=1:
  - All outputs=0 and Locked=0.
  - Next En=1 with GrayIn=011 gives Binary=2, Steps=0, Locked=1.
- Hold GrayIn=010 with En=1 for 4 cycles in TRACK:
  - No Steps change, Wrap=0, Error=0.
